// File: rtl/maze_engine_if.sv
// Player/game bus of the maze engine: setup and control strobes in, position/score/state out.
interface maze_engine_if #(
  parameter int unsigned GRID        = 8,
  parameter int unsigned STEP_DIGITS = 2
);
  localparam int unsigned CW = $clog2(GRID);
  localparam int unsigned NC = GRID * GRID;
  localparam int unsigned SW = 4 * STEP_DIGITS;

  logic          start;
  logic [NC-1:0] wall_map;
  logic [CW-1:0] start_row;
  logic [CW-1:0] start_col;
  logic [CW-1:0] goal_row;
  logic [CW-1:0] goal_col;
  logic [3:0]    key_pulse;
  logic          tick_1hz;
  logic          pause;
  logic [CW-1:0] pos_row;
  logic [CW-1:0] pos_col;
  logic [NC-1:0] pos_onehot;
  logic [SW-1:0] step_bcd;
  logic [7:0]    time_bcd;
  logic [2:0]    state;
  logic          bump;

  modport master (
    output start, wall_map, start_row, start_col, goal_row, goal_col,
           key_pulse, tick_1hz, pause,
    input  pos_row, pos_col, pos_onehot, step_bcd, time_bcd, state, bump
  );

  modport slave (
    input  start, wall_map, start_row, start_col, goal_row, goal_col,
           key_pulse, tick_1hz, pause,
    output pos_row, pos_col, pos_onehot, step_bcd, time_bcd, state, bump
  );
endinterface

// File: rtl/maze_engine.sv
// Maze game core: player position, game FSM, BCD step counter and BCD countdown.
// Optional macro MAZE_WALL_PENALTY_EN: blocked moves also deduct WALL_PENALTY seconds.
module maze_engine #(
  parameter int unsigned GRID         = 8,
  parameter int unsigned TIME_LIMIT   = 30,
  parameter int unsigned STEP_DIGITS  = 2,
  parameter int unsigned WALL_PENALTY = 5
) (
  input  logic         clk_in,
  input  logic         rst,
  maze_engine_if.slave bus
);
  localparam int unsigned CW = $clog2(GRID);
  localparam int unsigned NC = GRID * GRID;
  localparam int unsigned IW = $clog2(NC);
  localparam int unsigned SW = 4 * STEP_DIGITS;

  localparam logic [7:0]    TIME_INIT = {4'(TIME_LIMIT / 10), 4'(TIME_LIMIT % 10)};
  localparam logic [SW-1:0] STEP_MAX  = {STEP_DIGITS{4'h9}};
  localparam logic [CW-1:0] EDGE_HI   = CW'(GRID - 1);
  localparam logic [NC-1:0] CELL0     = NC'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    PAUSE = 3'd2,
    WIN   = 3'd3,
    LOSE  = 3'd4
  } state_t;

  if (GRID < 2 || GRID > 16) begin : g_bad_grid
    $error("maze_engine: GRID must be 2..16");
  end
  if (TIME_LIMIT < 1 || TIME_LIMIT > 99) begin : g_bad_time
    $error("maze_engine: TIME_LIMIT must be 1..99");
  end
  if (STEP_DIGITS < 1 || STEP_DIGITS > 4) begin : g_bad_steps
    $error("maze_engine: STEP_DIGITS must be 1..4");
  end
  if (WALL_PENALTY < 1 || WALL_PENALTY > 99) begin : g_bad_pen
    $error("maze_engine: WALL_PENALTY must be 1..99");
  end

  state_t        state_q,   state_d;
  logic [CW-1:0] pos_row_q, pos_row_d;
  logic [CW-1:0] pos_col_q, pos_col_d;
  logic [NC-1:0] onehot_q,  onehot_d;
  logic [SW-1:0] step_q,    step_d;
  logic [7:0]    time_q,    time_d;
  logic          bump_q,    bump_d;
  logic [NC-1:0] wall_q,    wall_d;
  logic [CW-1:0] goal_row_q, goal_row_d;
  logic [CW-1:0] goal_col_q, goal_col_d;

  logic          key_one;
  logic          off_grid;
  logic          blocked;
  logic [CW-1:0] tgt_row;
  logic [CW-1:0] tgt_col;
  logic [IW-1:0] tgt_idx;
  logic [SW-1:0] step_inc;
  logic          carry;
  logic [6:0]    time_bin;
  logic [6:0]    dec;
  logic [6:0]    time_left;
  logic [7:0]    time_dec;

  function automatic logic [IW-1:0] cell_idx(input logic [CW-1:0] r, input logic [CW-1:0] c);
    return IW'(r) * IW'(GRID) + IW'(c);
  endfunction

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pos_row_q  <= '0;
      pos_col_q  <= '0;
      onehot_q   <= CELL0;
      step_q     <= '0;
      time_q     <= TIME_INIT;
      bump_q     <= 1'b0;
      wall_q     <= '0;
      goal_row_q <= '0;
      goal_col_q <= '0;
    end else begin
      state_q    <= state_d;
      pos_row_q  <= pos_row_d;
      pos_col_q  <= pos_col_d;
      onehot_q   <= onehot_d;
      step_q     <= step_d;
      time_q     <= time_d;
      bump_q     <= bump_d;
      wall_q     <= wall_d;
      goal_row_q <= goal_row_d;
      goal_col_q <= goal_col_d;
    end
  end

  // Next-state: start overrides everything; moves and ticks only act in PLAY.
  always_comb begin
    state_d    = state_q;
    pos_row_d  = pos_row_q;
    pos_col_d  = pos_col_q;
    onehot_d   = onehot_q;
    step_d     = step_q;
    time_d     = time_q;
    bump_d     = 1'b0;
    wall_d     = wall_q;
    goal_row_d = goal_row_q;
    goal_col_d = goal_col_q;

    key_one  = $onehot(bus.key_pulse);
    off_grid = (bus.key_pulse[3] && pos_col_q == '0)     ||
               (bus.key_pulse[2] && pos_col_q == EDGE_HI) ||
               (bus.key_pulse[1] && pos_row_q == '0)     ||
               (bus.key_pulse[0] && pos_row_q == EDGE_HI);

    // Target stays clamped to the current cell when leaving the grid so the wall index is in range.
    tgt_row = pos_row_q;
    tgt_col = pos_col_q;
    if (!off_grid) begin
      if (bus.key_pulse[3]) tgt_col = pos_col_q - CW'(1);
      if (bus.key_pulse[2]) tgt_col = pos_col_q + CW'(1);
      if (bus.key_pulse[1]) tgt_row = pos_row_q - CW'(1);
      if (bus.key_pulse[0]) tgt_row = pos_row_q + CW'(1);
    end
    tgt_idx = cell_idx(tgt_row, tgt_col);
    blocked = key_one && (off_grid || wall_q[tgt_idx]);

    step_inc = step_q;
    carry    = 1'b1;
    for (int i = 0; i < int'(STEP_DIGITS); i++) begin
      if (carry) begin
        if (step_inc[4*i +: 4] == 4'h9) begin
          step_inc[4*i +: 4] = 4'h0;
        end else begin
          step_inc[4*i +: 4] = step_inc[4*i +: 4] + 4'h1;
          carry              = 1'b0;
        end
      end
    end
    if (step_q == STEP_MAX) step_inc = step_q;

    // Countdown arithmetic in binary, converted back to two BCD digits.
    time_bin = 7'(time_q[7:4]) * 7'd10 + 7'(time_q[3:0]);
    dec      = 7'(bus.tick_1hz);
`ifdef MAZE_WALL_PENALTY_EN
    if (blocked) dec = dec + 7'(WALL_PENALTY);
`else
`endif
    time_left = (dec >= time_bin) ? 7'd0 : time_bin - dec;
    time_dec  = {4'(time_left / 7'd10), 4'(time_left % 7'd10)};

    if (bus.start) begin
      wall_d     = bus.wall_map;
      goal_row_d = bus.goal_row;
      goal_col_d = bus.goal_col;
      pos_row_d  = bus.start_row;
      pos_col_d  = bus.start_col;
      onehot_d   = CELL0 << cell_idx(bus.start_row, bus.start_col);
      step_d     = '0;
      time_d     = TIME_INIT;
      state_d    = PLAY;
    end else begin
      case (state_q)
        PLAY: begin
          if (bus.pause) begin
            state_d = PAUSE;
          end else begin
            if (blocked) begin
              bump_d = 1'b1;
            end else if (key_one) begin
              pos_row_d = tgt_row;
              pos_col_d = tgt_col;
              onehot_d  = CELL0 << tgt_idx;
              step_d    = step_inc;
            end
            if (dec != 7'd0) time_d = time_dec;
            if (key_one && !blocked && tgt_row == goal_row_q && tgt_col == goal_col_q) begin
              state_d = WIN;
            end else if (dec != 7'd0 && time_left == 7'd0) begin
              state_d = LOSE;
            end
          end
        end
        PAUSE: begin
          if (!bus.pause) state_d = PLAY;
        end
        default: ;
      endcase
    end
  end

  assign bus.pos_row    = pos_row_q;
  assign bus.pos_col    = pos_col_q;
  assign bus.pos_onehot = onehot_q;
  assign bus.step_bcd   = step_q;
  assign bus.time_bcd   = time_q;
  assign bus.state      = state_q;
  assign bus.bump       = bump_q;
endmodule
